// File: rtl/tx_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, the main control FSM and the
// sample sources (training generators, IFFT symbol buffer, output mux).
interface tx_frame_sequencer_if #(
    parameter int SYM_LEN = 64
);
    localparam int AW = $clog2(SYM_LEN);

    logic          START;
    logic          ABORT;
    logic          SYM_READY;
    logic          SHORT_ACK;
    logic          LONG_ACK;
    logic          SYM_RD_EN;
    logic [AW-1:0] SYM_RD_ADDR;
    logic          SYM_RELEASE;
    logic [1:0]    SRC_SEL;
    logic          SAMPLE_VALID;
    logic [15:0]   FRAME_SYM_CNT;
    logic          UNDERRUN;
    logic          BUSY;
    logic          TRANSMISSION_DONE;

    modport master (
        output START, ABORT, SYM_READY,
        input  SHORT_ACK, LONG_ACK, SYM_RD_EN, SYM_RD_ADDR, SYM_RELEASE,
               SRC_SEL, SAMPLE_VALID, FRAME_SYM_CNT, UNDERRUN, BUSY,
               TRANSMISSION_DONE
    );

    modport slave (
        input  START, ABORT, SYM_READY,
        output SHORT_ACK, LONG_ACK, SYM_RD_EN, SYM_RD_ADDR, SYM_RELEASE,
               SRC_SEL, SAMPLE_VALID, FRAME_SYM_CNT, UNDERRUN, BUSY,
               TRANSMISSION_DONE
    );
endinterface

// File: rtl/tx_frame_sequencer.sv
// Sample-level scheduler for the VLC transmitter: short training, long training,
// CP + IFFT symbols, then a zero guard. Every output is registered from the next state.
module tx_frame_sequencer #(
    parameter int SHORT_LEN      = 320,
    parameter int LONG_LEN       = 288,
    parameter int SYM_LEN        = 64,
    parameter int CP_LEN         = 16,
    parameter int OFDM_FRAME_NUM = 100,
    parameter int GAP_LEN        = 32
) (
    input  logic SYS_CLK,
    input  logic S_SEQ_RST,
    tx_frame_sequencer_if.slave bus
);
    localparam int AW = $clog2(SYM_LEN);

    localparam logic [15:0]   SHORT_LAST = 16'(SHORT_LEN - 1);
    localparam logic [15:0]   LONG_LAST  = 16'(LONG_LEN - 1);
    localparam logic [15:0]   SYM_LAST   = 16'(SYM_LEN - 1);
    localparam logic [15:0]   CP_LAST    = 16'(CP_LEN - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_LEN - 1);
    localparam logic [15:0]   FRAME_N    = 16'(OFDM_FRAME_NUM);
    localparam logic [AW-1:0] CP_BASE    = AW'(SYM_LEN - CP_LEN);

    typedef enum logic [2:0] {IDLE, SHORT, LONG, WAIT_SYM, CP, BODY, GAP} state_t;

    // With no cyclic prefix a symbol starts directly in BODY.
    localparam state_t FIRST_SYM = (CP_LEN == 0) ? BODY : CP;

    state_t        state, nxt_state;
    logic [15:0]   cnt, nxt_cnt, sym_cnt_inc;
    logic [AW-1:0] cp_addr;
    logic          last;

    assign sym_cnt_inc = bus.FRAME_SYM_CNT + 16'd1;
    assign cp_addr     = CP_BASE + nxt_cnt[AW-1:0];

    always_comb begin
        last = 1'b0;
        case (state)
            SHORT:   last = (cnt == SHORT_LAST);
            LONG:    last = (cnt == LONG_LAST);
            CP:      last = (cnt == CP_LAST);
            BODY:    last = (cnt == SYM_LAST);
            GAP:     last = (cnt == GAP_LAST);
            default: last = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state = state;
        if (bus.ABORT) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:     if (bus.START) nxt_state = SHORT;
                SHORT:    if (last) nxt_state = LONG;
                LONG:     if (last) nxt_state = (FRAME_N == 16'd0) ? GAP :
                                                bus.SYM_READY ? FIRST_SYM : WAIT_SYM;
                WAIT_SYM: if (bus.SYM_READY) nxt_state = FIRST_SYM;
                CP:       if (last) nxt_state = BODY;
                BODY:     if (last) nxt_state = (sym_cnt_inc == FRAME_N) ? GAP :
                                                bus.SYM_READY ? FIRST_SYM : WAIT_SYM;
                GAP:      if (last) nxt_state = IDLE;
                default:  nxt_state = IDLE;
            endcase
        end
        // Re-entering BODY back-to-back (no CP) must also restart the count.
        nxt_cnt = (last || nxt_state != state || state == IDLE) ? 16'd0 : cnt + 16'd1;
    end

    always_ff @(posedge SYS_CLK) begin
        if (S_SEQ_RST) begin
            state                 <= IDLE;
            cnt                   <= 16'd0;
            bus.SHORT_ACK         <= 1'b0;
            bus.LONG_ACK          <= 1'b0;
            bus.SYM_RD_EN         <= 1'b0;
            bus.SYM_RD_ADDR       <= '0;
            bus.SYM_RELEASE       <= 1'b0;
            bus.SRC_SEL           <= 2'd0;
            bus.SAMPLE_VALID      <= 1'b0;
            bus.FRAME_SYM_CNT     <= 16'd0;
            bus.UNDERRUN          <= 1'b0;
            bus.BUSY              <= 1'b0;
            bus.TRANSMISSION_DONE <= 1'b0;
        end else begin
            state                 <= nxt_state;
            cnt                   <= nxt_cnt;
            bus.SHORT_ACK         <= (nxt_state == SHORT);
            bus.LONG_ACK          <= (nxt_state == LONG);
            bus.SYM_RD_EN         <= (nxt_state == CP) || (nxt_state == BODY);
            bus.SYM_RD_ADDR       <= (nxt_state == CP)   ? cp_addr :
                                     (nxt_state == BODY) ? nxt_cnt[AW-1:0] : '0;
            bus.SYM_RELEASE       <= (nxt_state == BODY) && (nxt_cnt == SYM_LAST);
            bus.SRC_SEL           <= (nxt_state == SHORT) ? 2'd1 :
                                     (nxt_state == LONG)  ? 2'd2 :
                                     (nxt_state == CP || nxt_state == BODY) ? 2'd3 : 2'd0;
            bus.SAMPLE_VALID      <= (nxt_state != IDLE);
            bus.BUSY              <= (nxt_state != IDLE);
            bus.TRANSMISSION_DONE <= !bus.ABORT && (state == GAP) && last;
            if (!bus.ABORT && state == IDLE && bus.START) begin
                bus.FRAME_SYM_CNT <= 16'd0;
                bus.UNDERRUN      <= 1'b0;
            end else begin
                if (!bus.ABORT && state == BODY && last)
                    bus.FRAME_SYM_CNT <= sym_cnt_inc;
                if (nxt_state == WAIT_SYM)
                    bus.UNDERRUN <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scenario-table bench for tx_frame_sequencer: per-cycle expected outputs come from
// segment arithmetic on the frame layout and are queued, then compared at negedge.
module tb_tx_frame_sequencer;
    typedef struct packed {
        logic        short_ack;
        logic        long_ack;
        logic        rd_en;
        logic [2:0]  addr;
        logic        rel;
        logic [1:0]  src;
        logic        valid;
        logic [15:0] cnt;
        logic        underrun;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        string name;
        int    dut;      // 0: N=3 CP=2, 1: N=0 CP=2, 2: N=3 CP=0
        int    ncyc;
        int    s2a, s2b; // extra START pulses (ignored while busy)
        int    abort_c;
        int    lo, hi;   // SYM_READY low in [lo, hi)
        int    rst_c, restart;
    } scn_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, ready = 1'b1;
    int   checks = 0, failures = 0;
    exp_t sb[$];
    exp_t got0, got1, got2;

    always #5 clk = ~clk;

    tx_frame_sequencer_if #(.SYM_LEN(8)) if0 ();
    tx_frame_sequencer_if #(.SYM_LEN(8)) if1 ();
    tx_frame_sequencer_if #(.SYM_LEN(8)) if2 ();

    assign if0.START = start; assign if0.ABORT = abort; assign if0.SYM_READY = ready;
    assign if1.START = start; assign if1.ABORT = abort; assign if1.SYM_READY = ready;
    assign if2.START = start; assign if2.ABORT = abort; assign if2.SYM_READY = ready;

    tx_frame_sequencer #(.SHORT_LEN(8), .LONG_LEN(6), .SYM_LEN(8), .CP_LEN(2),
                         .OFDM_FRAME_NUM(3), .GAP_LEN(4))
        dut0 (.SYS_CLK(clk), .S_SEQ_RST(rst), .bus(if0.slave));
    tx_frame_sequencer #(.SHORT_LEN(8), .LONG_LEN(6), .SYM_LEN(8), .CP_LEN(2),
                         .OFDM_FRAME_NUM(0), .GAP_LEN(4))
        dut1 (.SYS_CLK(clk), .S_SEQ_RST(rst), .bus(if1.slave));
    tx_frame_sequencer #(.SHORT_LEN(8), .LONG_LEN(6), .SYM_LEN(8), .CP_LEN(0),
                         .OFDM_FRAME_NUM(3), .GAP_LEN(4))
        dut2 (.SYS_CLK(clk), .S_SEQ_RST(rst), .bus(if2.slave));

    assign got0 = {if0.SHORT_ACK, if0.LONG_ACK, if0.SYM_RD_EN, if0.SYM_RD_ADDR, if0.SYM_RELEASE,
                   if0.SRC_SEL, if0.SAMPLE_VALID, if0.FRAME_SYM_CNT, if0.UNDERRUN, if0.BUSY,
                   if0.TRANSMISSION_DONE};
    assign got1 = {if1.SHORT_ACK, if1.LONG_ACK, if1.SYM_RD_EN, if1.SYM_RD_ADDR, if1.SYM_RELEASE,
                   if1.SRC_SEL, if1.SAMPLE_VALID, if1.FRAME_SYM_CNT, if1.UNDERRUN, if1.BUSY,
                   if1.TRANSMISSION_DONE};
    assign got2 = {if2.SHORT_ACK, if2.LONG_ACK, if2.SYM_RD_EN, if2.SYM_RD_ADDR, if2.SYM_RELEASE,
                   if2.SRC_SEL, if2.SAMPLE_VALID, if2.FRAME_SYM_CNT, if2.UNDERRUN, if2.BUSY,
                   if2.TRANSMISSION_DONE};

    // Outputs of an undisturbed frame whose START was sampled in cycle 0.
    function automatic exp_t normal_exp(int c, int n, int cp);
        exp_t e = '0;
        int   sl = cp + 8;
        int   g0 = 15 + n * sl;
        if (c >= 1 && c <= 8) begin
            e.short_ack = 1'b1; e.src = 2'd1; e.valid = 1'b1; e.busy = 1'b1;
        end else if (c >= 9 && c <= 14) begin
            e.long_ack = 1'b1; e.src = 2'd2; e.valid = 1'b1; e.busy = 1'b1;
        end else if (c >= 15 && c < g0) begin
            int k = (c - 15) / sl;
            int o = (c - 15) % sl;
            e.rd_en = 1'b1; e.src = 2'd3; e.valid = 1'b1; e.busy = 1'b1;
            e.cnt   = 16'(k);
            e.addr  = (o < cp) ? 3'(8 - cp + o) : 3'(o - cp);
            e.rel   = (o == sl - 1);
        end else if (c >= g0 && c < g0 + 4) begin
            e.valid = 1'b1; e.busy = 1'b1; e.cnt = 16'(n);
        end else if (c >= g0 + 4) begin
            e.cnt  = 16'(n);
            e.done = (c == g0 + 4);
        end
        return e;
    endfunction

    function automatic exp_t exp_for(scn_t s, int c);
        int   n  = (s.dut == 1) ? 0 : 3;
        int   cp = (s.dut == 2) ? 0 : 2;
        exp_t e  = '0;
        exp_t p;
        if (s.rst_c >= 0 && c > s.rst_c)
            return normal_exp((c < s.restart) ? 0 : c - s.restart, n, cp);
        if (s.abort_c >= 0 && c > s.abort_c) begin
            p = normal_exp(s.abort_c, n, cp);
            e.cnt = p.cnt;
            return e;
        end
        if (s.lo >= 0 && c > s.lo) begin
            if (c <= s.hi) begin
                p = normal_exp(s.lo + 1, n, cp);
                e.valid = 1'b1; e.busy = 1'b1; e.underrun = 1'b1; e.cnt = p.cnt;
            end else begin
                e = normal_exp(c - (s.hi - s.lo), n, cp);
                e.underrun = 1'b1;
            end
            return e;
        end
        return normal_exp(c, n, cp);
    endfunction

    task automatic check(string nm, int c, exp_t g, exp_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, g, e);
        end
    endtask

    task automatic run_scn(scn_t s);
        exp_t g, e;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < s.ncyc; c++) begin
            start = (c == 0) || (c == s.s2a) || (c == s.s2b) || (c == s.restart);
            abort = (c == s.abort_c);
            rst   = (c == s.rst_c);
            ready = !(s.lo >= 0 && c >= s.lo && c < s.hi);
            sb.push_back(exp_for(s, c));
            @(negedge clk);
            g = (s.dut == 0) ? got0 : (s.dut == 1) ? got1 : got2;
            e = sb.pop_front();
            check(s.name, c, g, e);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; ready = 1'b1;
    endtask

    // After an underrun frame: START+ABORT together is a no-op, a plain START clears
    // UNDERRUN and the count, and ABORT mid-frame drops to IDLE keeping the count.
    task automatic sticky_seq();
        exp_t e;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        e = '0; e.cnt = 16'd3; e.underrun = 1'b1;
        check("start_with_abort", 0, got0, e);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        e = '0; e.short_ack = 1'b1; e.src = 2'd1; e.valid = 1'b1; e.busy = 1'b1;
        check("start_clears_sticky", 1, got0, e);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        e = '0;
        check("abort_in_short", 2, got0, e);
    endtask

    scn_t scns[7];

    initial begin
        scns[0] = '{"normal",       0, 54, -1, -1, -1, -1, -1, -1, -1};
        scns[1] = '{"underrun",     0, 56, -1, -1, -1, 24, 27, -1, -1};
        scns[2] = '{"abort",        0, 40, -1, -1, 30, -1, -1, -1, -1};
        scns[3] = '{"ignored_start",0, 54,  5, 20, -1, -1, -1, -1, -1};
        scns[4] = '{"frame_num_0",  1, 24, -1, -1, -1, -1, -1, -1, -1};
        scns[5] = '{"cp_len_0",     2, 48, -1, -1, -1, -1, -1, -1, -1};
        scns[6] = '{"reset_mid",    0, 66, -1, -1, -1, -1, -1, 12, 14};

        for (int i = 0; i < 7; i++) begin
            run_scn(scns[i]);
            if (scns[i].lo >= 0) sticky_seq();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Sample-level scheduler for the DMT/OFDM VLC transmitter. It owns the single output sample path toward the DAC and shares it between three sources in a fixed order: the short training generator, the long training generator, and the IFFT symbol buffer with cyclic-prefix insertion. It counts data symbols and ends each frame with a zero guard. It reports completion on TRANSMISSION_DONE, which the main control FSM consumes to return to idle.

## Interface
- SHORT_LEN, 320: short-training length in samples (≥1)
- LONG_LEN, 288: long-training length in samples (≥1)
- SYM_LEN, 64: IFFT symbol length in samples; power of two, ≥4
- CP_LEN, 16: cyclic-prefix length (0 ≤ CP_LEN < SYM_LEN)
- OFDM_FRAME_NUM, 100: data symbols per frame (0..65535)
- GAP_LEN, 32: zero-sample guard after the last symbol (≥1)

Ports:
- SYS_CLK  in  1  sample clock; every element below is synchronous to it
- S_SEQ_RST  in  1  reset; synchronous, active-high
- START  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE
- ABORT  in  1  level; forces IDLE; priority over START
- SYM_READY  in  1  the buffer holds one complete IFFT symbol
- SHORT_ACK  out  1  short-training generator enable
- LONG_ACK  out  1  long-training generator enable
- SYM_RD_EN  out  1  symbol-buffer read strobe
- SYM_RD_ADDR  out  log2(SYM_LEN)  symbol-buffer read address
- SYM_RELEASE  out  1  one-cycle pulse: current symbol consumed, buffer may refill
- SRC_SEL  out  2  output mux select: 0 = zero, 1 = short, 2 = long, 3 = symbol
- SAMPLE_VALID  out  1  a sample is emitted this cycle
- FRAME_SYM_CNT  out  16  data symbols completed in the current frame
- UNDERRUN  out  1  sticky; set if a symbol was not ready when needed
- BUSY  out  1  state ≠ IDLE
- TRANSMISSION_DONE  out  1  one-cycle pulse at normal frame end

## Operation
- States: IDLE, SHORT, LONG, WAIT_SYM, CP, BODY, GAP.
- One internal 16-bit sample counter per state. It clears on every state entry. The state exits when the counter reaches LEN−1.
- IDLE:
  - START moves to SHORT.
  - START also clears FRAME_SYM_CNT and UNDERRUN.
- SHORT:
  - SHORT_ACK=1, SRC_SEL=1, SAMPLE_VALID=1 for SHORT_LEN cycles, then LONG.
- LONG:
  - LONG_ACK=1, SRC_SEL=2, SAMPLE_VALID=1 for LONG_LEN cycles.
  - If OFDM_FRAME_NUM=0, go to GAP.
  - Otherwise go to CP if SYM_READY=1 on the last cycle, else WAIT_SYM.
- WAIT_SYM:
  - SRC_SEL=0, SAMPLE_VALID=1 (zeros are emitted; the DAC stream never stalls).
  - UNDERRUN is set on every cycle spent here.
  - Moves to CP the cycle after SYM_READY=1 is sampled.
- CP:
  - SYM_RD_EN=1, SRC_SEL=3.
  - SYM_RD_ADDR = SYM_LEN−CP_LEN … SYM_LEN−1.
  - When CP_LEN=0, CP is skipped and the transition goes straight to BODY.
- BODY:
  - SYM_RD_EN=1, SRC_SEL=3, SYM_RD_ADDR = 0 … SYM_LEN−1.
  - On the last cycle: SYM_RELEASE=1 and FRAME_SYM_CNT increments.
  - Next state: if the incremented count equals OFDM_FRAME_NUM, go to GAP. Otherwise go to CP if SYM_READY=1 that cycle, else WAIT_SYM.
- GAP:
  - SRC_SEL=0, SAMPLE_VALID=1 for GAP_LEN cycles.
  - Then IDLE, with TRANSMISSION_DONE=1 in the first IDLE cycle.
- ABORT, or S_SEQ_RST:
  - The next cycle is IDLE with all strobes low.
  - No SYM_RELEASE, no TRANSMISSION_DONE.
  - FRAME_SYM_CNT and UNDERRUN hold their values on ABORT. On reset they are 0.
- START while BUSY is ignored with no side effect.

## Timing
- Reset values: every output is 0; SYM_RD_ADDR is 0; the state is IDLE.
- All outputs are registered.
- SRC_SEL, SAMPLE_VALID, SYM_RD_EN and SYM_RD_ADDR change together, one cycle after the state decision that selects them.
- The buffer's one-cycle read latency is compensated downstream by delaying SRC_SEL one cycle. This block adds no delay for it.
- START sampled in cycle t gives SHORT_ACK=1 from t+1.
- With SYM_READY held high, symbols are back-to-back: CP_LEN+SYM_LEN cycles each, with no gaps.
- Frame length with SYM_READY held high: SHORT_LEN + LONG_LEN + N·(CP_LEN+SYM_LEN) + GAP_LEN. TRANSMISSION_DONE follows on the next cycle.
- FRAME_SYM_CNT wraps modulo 2^16. It cannot exceed OFDM_FRAME_NUM in normal operation.

## Test plan
Parameters for all scenarios: SHORT_LEN=8, LONG_LEN=6, SYM_LEN=8, CP_LEN=2, OFDM_FRAME_NUM=3, GAP_LEN=4.
- Normal frame. SYM_READY=1 always; START at cycle 0.
  - SHORT_ACK high cycles 1–8; LONG_ACK high 9–14.
  - Symbols at 15–24, 25–34, 35–44. Addresses in each: 6, 7, 0…7.
  - SYM_RELEASE at 24, 34, 44. GAP 45–48. TRANSMISSION_DONE at 49.
  - FRAME_SYM_CNT=3, UNDERRUN=0.
- Underrun. SYM_READY goes low at cycle 24 and high at cycle 27.
  - WAIT_SYM for cycles 25–27, with SRC_SEL=0 and SAMPLE_VALID=1.
  - CP starts at 28 with address 6. UNDERRUN=1 until the next START.
- Abort. ABORT pulse at cycle 30.
  - Cycle 31: IDLE with all strobes 0, FRAME_SYM_CNT=1, no TRANSMISSION_DONE.
- Ignored START. START repeated at cycles 5 and 20.
  - Timing is identical to the normal frame.
- Parameter edge cases.
  - OFDM_FRAME_NUM=0: LONG goes straight to GAP; TRANSMISSION_DONE at cycle 19.
  - CP_LEN=0: each symbol is 8 cycles, addresses 0…7 only.
- Reset mid-frame. S_SEQ_RST at cycle 12.
  - Cycle 13: all outputs 0 and state IDLE.
  - A START at 14 restarts the frame, with SHORT_ACK high from cycle 15.
